// File: rtl/mig_port_arbiter.sv
// Two-master AXI4 arbiter for the shared MIG port: CPU (master 0) has fixed
// priority, the SD DMA (master 1) is forced through after STARVE_LIM lost
// rounds. AR/AW get an arbiter plus one-entry slice each; W follows AW order
// through a small FIFO of master indices; R/B route back on the id MSB.

// One address channel: arbiter, starvation counter, register slice and
// outstanding-transaction counter.
module mig_port_arbiter_ach #(
  parameter int ID_W       = 4,
  parameter int P_W        = 45,
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            v0,
  input  logic            v1,
  input  logic [ID_W-1:0] id0,
  input  logic [ID_W-1:0] id1,
  input  logic [P_W-1:0]  pl0,
  input  logic [P_W-1:0]  pl1,
  input  logic            room,
  input  logic            m_ready,
  input  logic            done,
  output logic            rdy0,
  output logic            rdy1,
  output logic            acc,
  output logic            sel,
  output logic            m_valid,
  output logic [ID_W:0]   m_id,
  output logic [P_W-1:0]  m_pl
);
  logic [7:0] starve;
  logic [3:0] outst;
  logic       can;

  // Master 1 wins when it is alone or when master 0 has starved it long enough.
  assign sel  = (v0 && v1) ? (starve >= 8'(STARVE_LIM)) : v1;
  assign can  = rstn && (!m_valid || m_ready) && (outst < 4'(MAX_OUTST)) && room;
  assign acc  = can && (v0 || v1);
  assign rdy0 = acc && !sel;
  assign rdy1 = acc && sel;

  // Slice load/drain, starvation tracking and outstanding count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_id    <= '0;
      m_pl    <= '0;
      starve  <= '0;
      outst   <= '0;
    end else begin
      if (acc) begin
        m_valid <= 1'b1;
        m_id    <= {sel, sel ? id1 : id0};
        m_pl    <= sel ? pl1 : pl0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (acc && sel)
        starve <= '0;
      else if (acc && v1 && starve != 8'hff)
        starve <= starve + 8'd1;
      case ({acc, done})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: ;
      endcase
    end
  end
endmodule

module mig_port_arbiter #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTST  = 4,
  parameter int STARVE_LIM = 8,
  parameter int WQ_DEPTH   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  // master 0 (CPU)
  input  logic [ID_W-1:0]   s0_ar_id,
  input  logic [ADDR_W-1:0] s0_ar_addr,
  input  logic [7:0]        s0_ar_len,
  input  logic [2:0]        s0_ar_size,
  input  logic [1:0]        s0_ar_burst,
  input  logic              s0_ar_valid,
  output logic              s0_ar_ready,
  output logic [ID_W-1:0]   s0_r_id,
  output logic [DATA_W-1:0] s0_r_data,
  output logic [1:0]        s0_r_resp,
  output logic              s0_r_last,
  output logic              s0_r_valid,
  input  logic              s0_r_ready,
  input  logic [ID_W-1:0]   s0_aw_id,
  input  logic [ADDR_W-1:0] s0_aw_addr,
  input  logic [7:0]        s0_aw_len,
  input  logic [2:0]        s0_aw_size,
  input  logic [1:0]        s0_aw_burst,
  input  logic              s0_aw_valid,
  output logic              s0_aw_ready,
  input  logic [DATA_W-1:0] s0_w_data,
  input  logic [DATA_W/8-1:0] s0_w_strb,
  input  logic              s0_w_last,
  input  logic              s0_w_valid,
  output logic              s0_w_ready,
  output logic [ID_W-1:0]   s0_b_id,
  output logic [1:0]        s0_b_resp,
  output logic              s0_b_valid,
  input  logic              s0_b_ready,
  // master 1 (SD DMA)
  input  logic [ID_W-1:0]   s1_ar_id,
  input  logic [ADDR_W-1:0] s1_ar_addr,
  input  logic [7:0]        s1_ar_len,
  input  logic [2:0]        s1_ar_size,
  input  logic [1:0]        s1_ar_burst,
  input  logic              s1_ar_valid,
  output logic              s1_ar_ready,
  output logic [ID_W-1:0]   s1_r_id,
  output logic [DATA_W-1:0] s1_r_data,
  output logic [1:0]        s1_r_resp,
  output logic              s1_r_last,
  output logic              s1_r_valid,
  input  logic              s1_r_ready,
  input  logic [ID_W-1:0]   s1_aw_id,
  input  logic [ADDR_W-1:0] s1_aw_addr,
  input  logic [7:0]        s1_aw_len,
  input  logic [2:0]        s1_aw_size,
  input  logic [1:0]        s1_aw_burst,
  input  logic              s1_aw_valid,
  output logic              s1_aw_ready,
  input  logic [DATA_W-1:0] s1_w_data,
  input  logic [DATA_W/8-1:0] s1_w_strb,
  input  logic              s1_w_last,
  input  logic              s1_w_valid,
  output logic              s1_w_ready,
  output logic [ID_W-1:0]   s1_b_id,
  output logic [1:0]        s1_b_resp,
  output logic              s1_b_valid,
  input  logic              s1_b_ready,
  // memory side
  output logic [ID_W:0]     m_ar_id,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [7:0]        m_ar_len,
  output logic [2:0]        m_ar_size,
  output logic [1:0]        m_ar_burst,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic [ID_W:0]     m_r_id,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_last,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  output logic [ID_W:0]     m_aw_id,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic [7:0]        m_aw_len,
  output logic [2:0]        m_aw_size,
  output logic [1:0]        m_aw_burst,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic              m_w_last,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  input  logic [ID_W:0]     m_b_id,
  input  logic [1:0]        m_b_resp,
  input  logic              m_b_valid,
  output logic              m_b_ready
);
  localparam int P_W = ADDR_W + 8 + 3 + 2;
  localparam int QA  = $clog2(WQ_DEPTH);

  logic ar_acc, ar_sel, aw_acc, aw_sel;
  logic r_done, b_done, w_pop;
  logic wq_full, wq_empty, wq_head, w_act;
  logic [WQ_DEPTH-1:0] wq_mem;
  logic [QA:0] wq_wr, wq_rd;

  mig_port_arbiter_ach #(.ID_W(ID_W), .P_W(P_W), .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)) u_ar (
    .clk(aclk), .rstn(aresetn), .v0(s0_ar_valid), .v1(s1_ar_valid),
    .id0(s0_ar_id), .id1(s1_ar_id),
    .pl0({s0_ar_addr, s0_ar_len, s0_ar_size, s0_ar_burst}),
    .pl1({s1_ar_addr, s1_ar_len, s1_ar_size, s1_ar_burst}),
    .room(1'b1), .m_ready(m_ar_ready), .done(r_done),
    .rdy0(s0_ar_ready), .rdy1(s1_ar_ready), .acc(ar_acc), .sel(ar_sel),
    .m_valid(m_ar_valid), .m_id(m_ar_id),
    .m_pl({m_ar_addr, m_ar_len, m_ar_size, m_ar_burst})
  );

  mig_port_arbiter_ach #(.ID_W(ID_W), .P_W(P_W), .MAX_OUTST(MAX_OUTST), .STARVE_LIM(STARVE_LIM)) u_aw (
    .clk(aclk), .rstn(aresetn), .v0(s0_aw_valid), .v1(s1_aw_valid),
    .id0(s0_aw_id), .id1(s1_aw_id),
    .pl0({s0_aw_addr, s0_aw_len, s0_aw_size, s0_aw_burst}),
    .pl1({s1_aw_addr, s1_aw_len, s1_aw_size, s1_aw_burst}),
    .room(!wq_full), .m_ready(m_aw_ready), .done(b_done),
    .rdy0(s0_aw_ready), .rdy1(s1_aw_ready), .acc(aw_acc), .sel(aw_sel),
    .m_valid(m_aw_valid), .m_id(m_aw_id),
    .m_pl({m_aw_addr, m_aw_len, m_aw_size, m_aw_burst})
  );

  assign wq_empty = (wq_wr == wq_rd);
  assign wq_full  = (wq_wr[QA] != wq_rd[QA]) && (wq_wr[QA-1:0] == wq_rd[QA-1:0]);
  assign wq_head  = wq_mem[wq_rd[QA-1:0]];

  // Write-order FIFO: one master index per accepted AW, popped on W last beat.
  // Head is only visible after the push is registered, so W never bypasses.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wq_mem <= '0;
      wq_wr  <= '0;
      wq_rd  <= '0;
    end else begin
      if (aw_acc) begin
        wq_mem[wq_wr[QA-1:0]] <= aw_sel;
        wq_wr <= wq_wr + 1'b1;
      end
      if (w_pop)
        wq_rd <= wq_rd + 1'b1;
    end
  end

  // W steering from the FIFO head; the non-selected master is held off.
  assign w_act      = aresetn && !wq_empty;
  assign m_w_valid  = w_act && (wq_head ? s1_w_valid : s0_w_valid);
  assign m_w_data   = w_act ? (wq_head ? s1_w_data : s0_w_data) : '0;
  assign m_w_strb   = w_act ? (wq_head ? s1_w_strb : s0_w_strb) : '0;
  assign m_w_last   = w_act && (wq_head ? s1_w_last : s0_w_last);
  assign s0_w_ready = w_act && !wq_head && m_w_ready;
  assign s1_w_ready = w_act && wq_head && m_w_ready;
  assign w_pop      = m_w_valid && m_w_ready && m_w_last;

  // R routing on the id MSB.
  logic r0, r1, b0, b1;
  assign r0 = aresetn && !m_r_id[ID_W];
  assign r1 = aresetn && m_r_id[ID_W];
  assign s0_r_valid = r0 && m_r_valid;
  assign s1_r_valid = r1 && m_r_valid;
  assign s0_r_id    = r0 ? m_r_id[ID_W-1:0] : '0;
  assign s1_r_id    = r1 ? m_r_id[ID_W-1:0] : '0;
  assign s0_r_data  = r0 ? m_r_data : '0;
  assign s1_r_data  = r1 ? m_r_data : '0;
  assign s0_r_resp  = r0 ? m_r_resp : '0;
  assign s1_r_resp  = r1 ? m_r_resp : '0;
  assign s0_r_last  = r0 && m_r_last;
  assign s1_r_last  = r1 && m_r_last;
  assign m_r_ready  = (r0 && s0_r_ready) || (r1 && s1_r_ready);
  assign r_done     = m_r_valid && m_r_ready && m_r_last;

  // B routing, same rule as R.
  assign b0 = aresetn && !m_b_id[ID_W];
  assign b1 = aresetn && m_b_id[ID_W];
  assign s0_b_valid = b0 && m_b_valid;
  assign s1_b_valid = b1 && m_b_valid;
  assign s0_b_id    = b0 ? m_b_id[ID_W-1:0] : '0;
  assign s1_b_id    = b1 ? m_b_id[ID_W-1:0] : '0;
  assign s0_b_resp  = b0 ? m_b_resp : '0;
  assign s1_b_resp  = b1 ? m_b_resp : '0;
  assign m_b_ready  = (b0 && s0_b_ready) || (b1 && s1_b_ready);
  assign b_done     = m_b_valid && m_b_ready;
endmodule

// File: tb/tb_mig_port_arbiter.sv
// Directed bench for mig_port_arbiter: reset, priority/starvation, read
// outstanding limit, write ordering, write-order FIFO full, response routing.
module tb_mig_port_arbiter;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32;

  logic aclk = 1'b0, aresetn;
  logic [ID_W-1:0] s0_ar_id, s1_ar_id, s0_aw_id, s1_aw_id;
  logic [ADDR_W-1:0] s0_ar_addr, s1_ar_addr, s0_aw_addr, s1_aw_addr;
  logic [7:0] s0_ar_len, s1_ar_len, s0_aw_len, s1_aw_len;
  logic [2:0] s0_ar_size, s1_ar_size, s0_aw_size, s1_aw_size;
  logic [1:0] s0_ar_burst, s1_ar_burst, s0_aw_burst, s1_aw_burst;
  logic s0_ar_valid, s1_ar_valid, s0_aw_valid, s1_aw_valid;
  logic s0_ar_ready, s1_ar_ready, s0_aw_ready, s1_aw_ready;
  logic [ID_W-1:0] s0_r_id, s1_r_id, s0_b_id, s1_b_id;
  logic [DATA_W-1:0] s0_r_data, s1_r_data, s0_w_data, s1_w_data, m_w_data, m_r_data;
  logic [1:0] s0_r_resp, s1_r_resp, s0_b_resp, s1_b_resp, m_r_resp, m_b_resp;
  logic s0_r_last, s1_r_last, s0_r_valid, s1_r_valid, s0_r_ready, s1_r_ready;
  logic [DATA_W/8-1:0] s0_w_strb, s1_w_strb, m_w_strb;
  logic s0_w_last, s1_w_last, s0_w_valid, s1_w_valid, s0_w_ready, s1_w_ready;
  logic s0_b_valid, s1_b_valid, s0_b_ready, s1_b_ready;
  logic [ID_W:0] m_ar_id, m_aw_id, m_r_id, m_b_id;
  logic [ADDR_W-1:0] m_ar_addr, m_aw_addr;
  logic [7:0] m_ar_len, m_aw_len;
  logic [2:0] m_ar_size, m_aw_size;
  logic [1:0] m_ar_burst, m_aw_burst;
  logic m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready;
  logic m_r_last, m_r_valid, m_r_ready;
  logic m_w_last, m_w_valid, m_w_ready;
  logic m_b_valid, m_b_ready;

  int n_checks = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  mig_port_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_ar_id(s0_ar_id), .s0_ar_addr(s0_ar_addr), .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size),
    .s0_ar_burst(s0_ar_burst), .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready),
    .s0_r_id(s0_r_id), .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
    .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
    .s0_aw_id(s0_aw_id), .s0_aw_addr(s0_aw_addr), .s0_aw_len(s0_aw_len), .s0_aw_size(s0_aw_size),
    .s0_aw_burst(s0_aw_burst), .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready),
    .s0_w_data(s0_w_data), .s0_w_strb(s0_w_strb), .s0_w_last(s0_w_last), .s0_w_valid(s0_w_valid),
    .s0_w_ready(s0_w_ready), .s0_b_id(s0_b_id), .s0_b_resp(s0_b_resp), .s0_b_valid(s0_b_valid),
    .s0_b_ready(s0_b_ready),
    .s1_ar_id(s1_ar_id), .s1_ar_addr(s1_ar_addr), .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size),
    .s1_ar_burst(s1_ar_burst), .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready),
    .s1_r_id(s1_r_id), .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
    .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
    .s1_aw_id(s1_aw_id), .s1_aw_addr(s1_aw_addr), .s1_aw_len(s1_aw_len), .s1_aw_size(s1_aw_size),
    .s1_aw_burst(s1_aw_burst), .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready),
    .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb), .s1_w_last(s1_w_last), .s1_w_valid(s1_w_valid),
    .s1_w_ready(s1_w_ready), .s1_b_id(s1_b_id), .s1_b_resp(s1_b_resp), .s1_b_valid(s1_b_valid),
    .s1_b_ready(s1_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last), .m_w_valid(m_w_valid),
    .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready)
  );

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    s0_ar_id = 4'h2; s0_ar_addr = 32'h1000; s0_ar_len = 0; s0_ar_size = 3'd2; s0_ar_burst = 2'd1;
    s1_ar_id = 4'h3; s1_ar_addr = 32'h2000; s1_ar_len = 0; s1_ar_size = 3'd2; s1_ar_burst = 2'd1;
    s0_aw_id = 4'h4; s0_aw_addr = 32'h3000; s0_aw_len = 0; s0_aw_size = 3'd2; s0_aw_burst = 2'd1;
    s1_aw_id = 4'h6; s1_aw_addr = 32'h4000; s1_aw_len = 0; s1_aw_size = 3'd2; s1_aw_burst = 2'd1;
    s0_ar_valid = 0; s1_ar_valid = 0; s0_aw_valid = 0; s1_aw_valid = 0;
    s0_r_ready = 0; s1_r_ready = 0; s0_b_ready = 0; s1_b_ready = 0;
    s0_w_data = 0; s1_w_data = 0; s0_w_strb = 4'hf; s1_w_strb = 4'hf;
    s0_w_last = 0; s1_w_last = 0; s0_w_valid = 0; s1_w_valid = 0;
    m_ar_ready = 0; m_aw_ready = 0; m_w_ready = 0;
    m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0; m_r_valid = 0;
    m_b_id = 0; m_b_resp = 0; m_b_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    aresetn = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    idle();
    aresetn = 0;
    s0_ar_valid = 1; s1_ar_valid = 1; s0_aw_valid = 1; s1_aw_valid = 1;
    s0_w_valid = 1; s1_w_valid = 1; s0_w_last = 1; s1_w_last = 1;
    s0_r_ready = 1; s1_r_ready = 1; s0_b_ready = 1; s1_b_ready = 1;
    m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
    m_r_valid = 1; m_r_last = 1; m_b_valid = 1; m_b_id = 5'h10;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      outs = {s0_ar_ready, s1_ar_ready, s0_aw_ready, s1_aw_ready, s0_w_ready, s1_w_ready,
              s0_r_valid, s1_r_valid, s0_b_valid, s1_b_valid, m_ar_valid, m_aw_valid,
              m_w_valid, m_r_ready, m_b_ready, 1'b0};
      n_checks++;
      if (outs !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0000", c, outs);
      end
    end
    // release; first cycle out of reset must accept the s0 AR
    tick();
    aresetn = 1; m_r_valid = 0; m_b_valid = 0;
    s0_aw_valid = 0; s1_aw_valid = 0; s0_w_valid = 0; s1_w_valid = 0;
    #1;
    n_checks++;
    if ({s0_ar_ready, s1_ar_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_accept: got %b want 10", {s0_ar_ready, s1_ar_ready});
    end
    tick();
    s0_ar_valid = 0; s1_ar_valid = 0;
    #1;
    n_checks++;
    if ({m_ar_valid, m_ar_id} !== {1'b1, 5'h02}) begin
      n_fail++;
      $display("FAIL reset_first_slice: got %b/%h want 1/02", m_ar_valid, m_ar_id);
    end
  endtask

  task automatic test_priority();
    logic g, prev;
    do_reset();
    tick();
    aresetn = 1;
    s0_ar_valid = 1; s1_ar_valid = 1; m_ar_ready = 1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin
        m_r_valid = 1; m_r_last = 1; m_r_id = 5'h00; s0_r_ready = 1;
      end
      #1;
      g = (i % 9 == 8);
      n_checks++;
      if ({s0_ar_ready, s1_ar_ready} !== {~g, g}) begin
        n_fail++;
        $display("FAIL prio_grant cycle %0d: got %b want %b", i, {s0_ar_ready, s1_ar_ready}, {~g, g});
      end
      if (i > 0) begin
        n_checks++;
        if ({m_ar_valid, m_ar_id} !== {1'b1, prev ? 5'h13 : 5'h02}) begin
          n_fail++;
          $display("FAIL prio_m_ar_id cycle %0d: got %b/%h want 1/%h", i, m_ar_valid, m_ar_id,
                   prev ? 5'h13 : 5'h02);
        end
      end
      prev = g;
      tick();
    end
    idle();
  endtask

  task automatic test_outstanding();
    do_reset();
    tick();
    aresetn = 1;
    s0_ar_valid = 1; s1_ar_valid = 1; m_ar_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ((s0_ar_ready | s1_ar_ready) !== (i < 4)) begin
        n_fail++;
        $display("FAIL outst_accept cycle %0d: got %b want %b", i, s0_ar_ready | s1_ar_ready, i < 4);
      end
      tick();
    end
    m_r_valid = 1; m_r_last = 1; m_r_id = 5'h05; m_r_data = 32'hdead_beef; s0_r_ready = 1;
    #1;
    n_checks++;
    if ({s0_r_valid, s0_r_id, s1_r_valid, m_r_ready, s0_r_data} !== {1'b1, 4'h5, 1'b0, 1'b1, 32'hdead_beef}) begin
      n_fail++;
      $display("FAIL outst_r_route: got v%b id%h v1%b rdy%b d%h want v1 id5 v10 rdy1 ddeadbeef",
               s0_r_valid, s0_r_id, s1_r_valid, m_r_ready, s0_r_data);
    end
    n_checks++;
    if ((s0_ar_ready | s1_ar_ready) !== 1'b0) begin
      n_fail++;
      $display("FAIL outst_same_cycle: got %b want 0", s0_ar_ready | s1_ar_ready);
    end
    tick();
    m_r_valid = 0;
    #1;
    n_checks++;
    if ({s0_ar_ready, s1_ar_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL outst_refill: got %b want 10", {s0_ar_ready, s1_ar_ready});
    end
    tick();
    #1;
    n_checks++;
    if ((s0_ar_ready | s1_ar_ready) !== 1'b0) begin
      n_fail++;
      $display("FAIL outst_full_again: got %b want 0", s0_ar_ready | s1_ar_ready);
    end
    idle();
  endtask

  task automatic test_write_order();
    logic [31:0] exp_d;
    do_reset();
    tick();
    aresetn = 1;
    m_aw_ready = 1; m_w_ready = 1;
    s0_w_valid = 1; s0_w_last = 1; s0_w_data = 32'ha0;
    s1_aw_valid = 1; s1_aw_len = 8'd3;
    #1;
    n_checks++;
    if ({s1_aw_ready, s0_w_ready, m_w_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_aw1: got %b want 100", {s1_aw_ready, s0_w_ready, m_w_valid});
    end
    tick();
    s1_aw_valid = 0; s0_aw_valid = 1; s0_aw_len = 8'd0;
    for (int b = 0; b < 4; b++) begin
      s1_w_valid = 1; s1_w_data = 32'hb0 + b; s1_w_last = (b == 3);
      #1;
      exp_d = 32'hb0 + b;
      if (b == 0) begin
        n_checks++;
        if ({s0_aw_ready, m_aw_valid, m_aw_id, m_aw_len} !== {1'b1, 1'b1, 5'h16, 8'd3}) begin
          n_fail++;
          $display("FAIL wr_aw2: got rdy%b v%b id%h len%0d want 1 1 16 3",
                   s0_aw_ready, m_aw_valid, m_aw_id, m_aw_len);
        end
      end
      if (b == 1) begin
        n_checks++;
        if ({m_aw_valid, m_aw_id, m_aw_len} !== {1'b1, 5'h04, 8'd0}) begin
          n_fail++;
          $display("FAIL wr_aw2_slice: got v%b id%h len%0d want 1 04 0", m_aw_valid, m_aw_id, m_aw_len);
        end
      end
      n_checks++;
      if ({m_w_valid, m_w_data, m_w_last, s1_w_ready, s0_w_ready} !== {1'b1, exp_d, b == 3, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL wr_s1_beat %0d: got v%b d%h l%b r1%b r0%b want 1 %h %b 1 0",
                 b, m_w_valid, m_w_data, m_w_last, s1_w_ready, s0_w_ready, exp_d, b == 3);
      end
      tick();
      s0_aw_valid = 0;
    end
    s1_w_valid = 0; s1_w_last = 0;
    #1;
    n_checks++;
    if ({m_w_valid, m_w_data, m_w_last, s0_w_ready, s1_w_ready} !== {1'b1, 32'ha0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_s0_beat: got v%b d%h l%b r0%b r1%b want 1 a0 1 1 0",
               m_w_valid, m_w_data, m_w_last, s0_w_ready, s1_w_ready);
    end
    tick();
    s0_w_valid = 0;
    #1;
    n_checks++;
    if ({m_w_valid, s0_w_ready, s1_w_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_empty: got %b want 000", {m_w_valid, s0_w_ready, s1_w_ready});
    end
    idle();
  endtask

  task automatic test_wq_full();
    do_reset();
    tick();
    aresetn = 1;
    m_aw_ready = 1; s0_aw_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (s0_aw_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL wq_accept cycle %0d: got %b want %b", i, s0_aw_ready, i < 4);
      end
      tick();
    end
    // one B frees an outstanding slot; the FIFO is still full
    m_b_valid = 1; m_b_id = 5'h04; s0_b_ready = 1;
    #1;
    n_checks++;
    if ({s0_b_valid, s0_b_id, m_b_ready, s0_aw_ready} !== {1'b1, 4'h4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wq_b_beat: got v%b id%h rdy%b awr%b want 1 4 1 0", s0_b_valid, s0_b_id, m_b_ready, s0_aw_ready);
    end
    tick();
    m_b_valid = 0;
    #1;
    n_checks++;
    if (s0_aw_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wq_still_full: got %b want 0", s0_aw_ready);
    end
    tick();
    s0_w_valid = 1; s0_w_last = 1; m_w_ready = 1;
    #1;
    n_checks++;
    if ({s0_w_ready, s0_aw_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL wq_pop_cycle: got %b want 10", {s0_w_ready, s0_aw_ready});
    end
    tick();
    s0_w_valid = 0; m_w_ready = 0;
    #1;
    n_checks++;
    if (s0_aw_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wq_after_pop: got %b want 1", s0_aw_ready);
    end
    tick();
    idle();
  endtask

  task automatic test_b_route();
    logic [2:0] rdy_seq;
    do_reset();
    tick();
    aresetn = 1;
    rdy_seq = 3'b101;
    m_b_valid = 1; m_b_id = 5'h1A; m_b_resp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      s1_b_ready = rdy_seq[i];
      #1;
      n_checks++;
      if ({s1_b_valid, s1_b_id, s1_b_resp, s0_b_valid, m_b_ready} !== {1'b1, 4'hA, 2'b10, 1'b0, rdy_seq[i]}) begin
        n_fail++;
        $display("FAIL b_route %0d: got v1%b id%h resp%b v0%b rdy%b want 1 a 10 0 %b",
                 i, s1_b_valid, s1_b_id, s1_b_resp, s0_b_valid, m_b_ready, rdy_seq[i]);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_outstanding();
    test_write_order();
    test_wq_full();
    test_b_route();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
